// File: rtl/xmem_pkg.sv
// Shared definitions for the external data memory request controller:
// FSM encoding, memory read latency and the request-entry layout.
package xmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } xmem_state_e;

    // Clocks from the memory latching a read until its data sits on dm_bc_dt.
    localparam int XMEM_RD_LAT = 2;

    // A queued request is packed as {wrb, add, dt}, wrb in the MSB.
    function automatic int xmem_entry_w(input int add_w, input int dt_w);
        return 1 + add_w + dt_w;
    endfunction

    function automatic int xmem_entry_wrb_bit(input int add_w, input int dt_w);
        return add_w + dt_w;
    endfunction

    function automatic int xmem_entry_add_lsb(input int dt_w);
        return dt_w;
    endfunction

endpackage

// File: rtl/xmem_req_fifo.sv
// Synchronous request FIFO; pointers wrap modulo depth and the count carries
// one extra bit so that full and empty are distinguishable.
module xmem_req_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/xmem_req_ctrl.sv
// Request controller in front of the single-port external data memory.
// Optional XMEM_PERF_CNT_EN adds saturating read/write issue counters.
module xmem_req_ctrl
    import xmem_pkg::*;
#(
    parameter int DMA_SIZE        = 3,
    parameter int DMD_SIZE        = 4,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic                req_wrb,
    input  logic [DMA_SIZE-1:0] req_add,
    input  logic [DMD_SIZE-1:0] req_dt,
    output logic                rsp_vld,
    output logic [DMD_SIZE-1:0] rsp_dt,
    input  logic                flush,
    output logic                idle,
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt
`ifdef XMEM_PERF_CNT_EN
    ,
    output logic [15:0]         rd_cnt,
    output logic [15:0]         wr_cnt
`endif
);
    localparam int ENT_W   = xmem_entry_w(DMA_SIZE, DMD_SIZE);
    localparam int WRB_BIT = xmem_entry_wrb_bit(DMA_SIZE, DMD_SIZE);
    localparam int ADD_LSB = xmem_entry_add_lsb(DMD_SIZE);

    logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]         fifo_din, fifo_dout;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    logic                     head_wrb;
    logic [DMA_SIZE-1:0]      head_add;
    logic [DMD_SIZE-1:0]      head_dt;
    logic                     rd_on_bus;
    logic                     drained;

    xmem_state_e              state_q, state_d;
    logic                     cslt_q, cslt_d;
    logic                     wrb_q, wrb_d;
    logic [DMA_SIZE-1:0]      add_q, add_d;
    logic [DMD_SIZE-1:0]      dt_q, dt_d;
    logic [XMEM_RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;
    logic                     rsp_vld_q, rsp_vld_d;
    logic [DMD_SIZE-1:0]      rsp_dt_q, rsp_dt_d;

    assign req_rdy   = !fifo_full && !flush;
    assign fifo_push = req_vld && req_rdy;
    assign fifo_din  = {req_wrb, req_add, req_dt};

    assign head_wrb  = fifo_dout[WRB_BIT];
    assign head_add  = fifo_dout[ADD_LSB +: DMA_SIZE];
    assign head_dt   = fifo_dout[DMD_SIZE-1:0];

    assign fifo_pop  = ((state_q == ISSUE) || (state_q == DRAIN)) && !fifo_empty;
    assign rd_on_bus = cslt_q && !wrb_q;
    assign drained   = fifo_empty && (rd_pipe_q == '0);

    xmem_req_fifo #(
        .WIDTH      (ENT_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rstb      (rstb),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (drained) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Address and write data park on their last values between requests.
        cslt_d = 1'b0;
        wrb_d  = 1'b0;
        add_d  = add_q;
        dt_d   = dt_q;
        if (fifo_pop) begin
            cslt_d = 1'b1;
            wrb_d  = head_wrb;
            add_d  = head_add;
            dt_d   = head_dt;
        end

        // A read on the bus in cycle N returns dm_bc_dt sampled at the end of N+2.
        rd_pipe_d = {rd_pipe_q[XMEM_RD_LAT-2:0], rd_on_bus};
        rsp_vld_d = rd_pipe_q[XMEM_RD_LAT-1];
        rsp_dt_d  = rd_pipe_q[XMEM_RD_LAT-1] ? dm_bc_dt : rsp_dt_q;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            cslt_q    <= 1'b0;
            wrb_q     <= 1'b0;
            add_q     <= '0;
            dt_q      <= '0;
            rd_pipe_q <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cslt_q    <= cslt_d;
            wrb_q     <= wrb_d;
            add_q     <= add_d;
            dt_q      <= dt_d;
            rd_pipe_q <= rd_pipe_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dt_q  <= rsp_dt_d;
        end
    end

    assign ps_dm_cslt = cslt_q;
    assign ps_dm_wrb  = wrb_q;
    assign dg_dm_add  = add_q;
    assign bc_dt      = dt_q;
    assign rsp_vld    = rsp_vld_q;
    assign rsp_dt     = rsp_dt_q;
    assign idle       = (state_q == IDLE) && (fifo_count == '0) && (rd_pipe_q == '0);

`ifdef XMEM_PERF_CNT_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counted at pop, i.e. the edge that drives the request onto the bus.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (fifo_pop && !head_wrb) begin
            rd_cnt_d = sat_inc16(rd_cnt_q);
        end
        if (fifo_pop && head_wrb) begin
            wr_cnt_d = sat_inc16(wr_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_xmem_req_ctrl.sv
// Bench for xmem_req_ctrl: directed phases plus random traffic, checked against
// a transaction-level model (request queue, reference memory, response due times).
module tb_xmem_req_ctrl;
    localparam int AW    = 3;
    localparam int DW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          req_vld = 1'b0;
    logic          req_wrb = 1'b0;
    logic [AW-1:0] req_add = '0;
    logic [DW-1:0] req_dt = '0;
    logic          flush = 1'b0;
    logic          req_rdy, rsp_vld, idle, ps_dm_cslt, ps_dm_wrb;
    logic [DW-1:0] rsp_dt, bc_dt;
    logic [AW-1:0] dg_dm_add;
    logic [DW-1:0] dm_bc_dt = '0;
`ifdef XMEM_PERF_CNT_EN
    logic [15:0]   rd_cnt, wr_cnt;
`endif

    always #5 clk = ~clk;

    xmem_req_ctrl #(.DMA_SIZE(AW), .DMD_SIZE(DW), .FIFO_DEPTH_LOG2(2)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_wrb    (req_wrb),
        .req_add    (req_add),
        .req_dt     (req_dt),
        .rsp_vld    (rsp_vld),
        .rsp_dt     (rsp_dt),
        .flush      (flush),
        .idle       (idle),
        .ps_dm_cslt (ps_dm_cslt),
        .ps_dm_wrb  (ps_dm_wrb),
        .dg_dm_add  (dg_dm_add),
        .bc_dt      (bc_dt),
        .dm_bc_dt   (dm_bc_dt)
`ifdef XMEM_PERF_CNT_EN
        ,
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
`endif
    );

    // External memory: latches control on one edge, acts on the next.
    logic          m_cs = 1'b0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_add = '0;
    logic [DW-1:0] m_dt = '0;
    logic [DW-1:0] mem [8] = '{default: '0};

    always @(posedge clk) begin
        m_cs  <= ps_dm_cslt;
        m_wr  <= ps_dm_wrb;
        m_add <= dg_dm_add;
        m_dt  <= bc_dt;
        if (m_cs && m_wr) mem[m_add] <= m_dt;
        if (m_cs && !m_wr) dm_bc_dt <= mem[m_add];
    end

    typedef struct packed {
        logic          wrb;
        logic [AW-1:0] add;
        logic [DW-1:0] dt;
    } req_t;

    typedef struct {
        int            due;
        logic [DW-1:0] dt;
    } rsp_t;

    req_t          pend_q[$];
    rsp_t          rsp_q[$];
    logic [DW-1:0] ref_mem [8];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            stall = 0;
    bit            must_issue = 0;
    int            n_rd = 0;
    int            n_wr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic observe();
        req_t r;
        rsp_t e;
        if (!rstb) begin
            chk("rst_cslt", ps_dm_cslt, 0);
            chk("rst_rsp_vld", rsp_vld, 0);
            chk("rst_idle", idle, 1);
            return;
        end
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            chk("rsp_vld", rsp_vld, 1);
            chk("rsp_dt", rsp_dt, rsp_q[0].dt);
            void'(rsp_q.pop_front());
        end else begin
            chk("rsp_vld_quiet", rsp_vld, 0);
        end
        if (must_issue) chk("no_bubble", ps_dm_cslt, 1);
        must_issue = 0;
        if (ps_dm_cslt === 1'b1) begin
            stall = 0;
            if (pend_q.size() == 0) begin
                chk("spurious_issue", ps_dm_cslt, 0);
            end else begin
                r = pend_q.pop_front();
                chk("iss_wrb", ps_dm_wrb, r.wrb);
                chk("iss_add", dg_dm_add, r.add);
                if (r.wrb) begin
                    chk("iss_dt", bc_dt, r.dt);
                    ref_mem[r.add] = r.dt;
                    n_wr++;
                end else begin
                    e.due = cyc + 3;
                    e.dt  = ref_mem[r.add];
                    rsp_q.push_back(e);
                    n_rd++;
                end
                must_issue = (pend_q.size() > 0);
            end
        end else begin
            chk("wrb_idle", ps_dm_wrb, 0);
            if (pend_q.size() > 0) stall++;
            else stall = 0;
            if (stall == 3) begin
                chk("issue_timeout", ps_dm_cslt, 1);
                stall = 0;
            end
        end
        if (pend_q.size() > 0 || ps_dm_cslt === 1'b1 || rsp_q.size() > 0)
            chk("idle_busy", idle, 0);
    endtask

    // One clock: drive at the falling edge, sample at the next falling edge.
    task automatic step(input logic vld, input logic wrb, input logic [AW-1:0] add,
                        input logic [DW-1:0] dt, input logic fl);
        bit   exp_rdy;
        req_t r;
        req_vld = vld;
        req_wrb = wrb;
        req_add = add;
        req_dt  = dt;
        flush   = fl;
        #1;
        exp_rdy = (pend_q.size() < DEPTH) && !fl;
        chk("req_rdy", req_rdy, exp_rdy);
        if (vld && exp_rdy && rstb) begin
            r.wrb = wrb;
            r.add = add;
            r.dt  = dt;
            pend_q.push_back(r);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
        chk("idle_quiet", idle, 1);
    endtask

    task automatic reset_now();
        rstb = 1'b0;
        pend_q.delete();
        rsp_q.delete();
        must_issue = 0;
        stall = 0;
        n_rd = 0;
        n_wr = 0;
        #1;
        chk("rst_async_cslt", ps_dm_cslt, 0);
        chk("rst_async_rsp", rsp_vld, 0);
        chk("rst_async_idle", idle, 1);
        chk("rst_async_rdy", req_rdy, 1);
    endtask

    initial begin
        int flush_left;
        logic fl;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;

        // Reset held with a request offered: nothing may be accepted.
        @(negedge clk);
        reset_now();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd5, 4'h7, 1'b0);
        rstb = 1'b1;
        settle(4);

        // Write then read the same address back to back.
        step(1'b1, 1'b1, 3'd3, 4'hA, 1'b0);
        step(1'b1, 1'b0, 3'd3, 4'h0, 1'b0);
        settle(8);

        // Five requests with no gaps.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1'b0);
        settle(8);

        // Queue four, then flush with a request still offered.
        step(1'b1, 1'b1, 3'd1, 4'h3, 1'b0);
        step(1'b1, 1'b0, 3'd1, 4'h0, 1'b0);
        step(1'b1, 1'b1, 3'd6, 4'hC, 1'b0);
        step(1'b1, 1'b0, 3'd6, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'd0, 4'hF, 1'b1);
        settle(3);

        // Flush dropped while draining: acceptance resumes immediately.
        step(1'b1, 1'b1, 3'd2, 4'h9, 1'b0);
        step(1'b1, 1'b0, 3'd2, 4'h0, 1'b0);
        step(1'b1, 1'b0, 3'd1, 4'h0, 1'b1);
        step(1'b1, 1'b1, 3'd4, 4'h5, 1'b0);
        step(1'b1, 1'b0, 3'd4, 4'h0, 1'b0);
        settle(8);

        // Reset with two reads in flight: their responses must never appear.
        step(1'b1, 1'b0, 3'd3, 4'h0, 1'b0);
        step(1'b1, 1'b0, 3'd6, 4'h0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        reset_now();
        step(1'b0, 1'b0, '0, '0, 1'b0);
        rstb = 1'b1;
        settle(6);

        // Random traffic with occasional flush windows.
        flush_left = 0;
        for (int i = 0; i < 400; i++) begin
            if (flush_left == 0 && $urandom_range(0, 19) == 0)
                flush_left = int'($urandom_range(1, 6));
            fl = (flush_left > 0);
            if (flush_left > 0) flush_left--;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 AW'($urandom), DW'($urandom), fl);
        end
        settle(10);

`ifdef XMEM_PERF_CNT_EN
        @(negedge clk);
        reset_now();
        step(1'b0, 1'b0, '0, '0, 1'b0);
        rstb = 1'b1;
        step(1'b1, 1'b1, 3'd0, 4'h1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 3'd1, 4'h2, 1'b0);
        step(1'b1, 1'b0, 3'd1, 4'h0, 1'b0);
        step(1'b1, 1'b1, 3'd2, 4'h3, 1'b0);
        settle(8);
        chk("wr_cnt", wr_cnt, n_wr);
        chk("rd_cnt", rd_cnt, n_rd);
`endif

        chk("final_rsp_drained", rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
